// File: rtl/periph_bus_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : periph_bus_arbiter_if                                      |
// | Description : One master's request/ack port into periph_bus_arbiter.     |
// |               The arbiter has two of these ports, one for each master.   |
// |   req   master -> arbiter  transaction request, held until ack           |
// |   we    master -> arbiter  1 = write, 0 = read                           |
// |   addr  master -> arbiter  register address                              |
// |   wdata master -> arbiter  write data                                    |
// |   lock  master -> arbiter  keep the bus owned after this transaction     |
// |   ack   arbiter -> master  one-cycle completion pulse                    |
// |   rdata arbiter -> master  read data, valid with ack, held until next ack|
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface periph_bus_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              lock;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, lock, input ack, rdata);
   modport slave  (input req, we, addr, wdata, lock, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/periph_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : periph_bus_arbiter                                         |
// | Description : Shares the peripheral register bus (A/WD/WE/RD) between    |
// |               m0 (CPU data port) and m1 (debug/DMA bridge). Round-robin  |
// |               arbitration, req/ack handshake, one-cycle write strobes    |
// |               and an optional bus lock with an idle-owner timeout.       |
// | Ports       :                                                            |
// |   clk, rst_n    clock (rising edge), asynchronous active-low reset       |
// |   m0, m1        master ports (periph_bus_arbiter_if.slave)               |
// |   p_A, p_WD     address / write data to peripherals (held between uses)  |
// |   p_WE          write strobe to peripherals, high in ACCESS only         |
// |   p_RD          combinational read data from peripherals                 |
// |   lock_timeout  one-cycle pulse when a held lock is force-released       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module periph_bus_arbiter #(
   parameter int ADDR_W       = 5,
   parameter int DATA_W       = 32,
   parameter int LOCK_TIMEOUT = 16
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   periph_bus_arbiter_if.slave    m0,
   periph_bus_arbiter_if.slave    m1,
   output logic [ADDR_W-1:0]      p_A,
   output logic [DATA_W-1:0]      p_WD,
   output logic                   p_WE,
   input  wire logic [DATA_W-1:0] p_RD,
   output logic                   lock_timeout
);

   localparam int                 c_CNT_W    = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_owner;        // current / most recent grantee, also lock owner
   logic                r_we;
   logic                r_last_grant;
   logic                r_lock_active;
   logic [c_CNT_W-1:0]  r_cnt;
   logic                r_ack0;
   logic                r_ack1;
   logic [DATA_W-1:0]   r_rdata0;
   logic [DATA_W-1:0]   r_rdata1;

   logic [1:0]          w_req;
   logic                w_owner_req;
   logic                w_force_release;
   logic                w_lock_hold;
   logic [1:0]          w_elig;
   logic                w_gnt;
   logic                w_sel_we;
   logic                w_sel_lock;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;

   assign w_req       = {m1.req, m0.req};
   assign w_owner_req = r_owner ? m1.req : m0.req;

   // The idle cycle that completes the timeout already arbitrates as if the
   // lock were gone, so a waiting master is granted without an extra cycle.
   assign w_force_release = (r_state == S_IDLE) && r_lock_active && !w_owner_req &&
                            (r_cnt == c_CNT_LAST);
   assign w_lock_hold     = r_lock_active && !w_force_release;
   assign w_elig          = w_lock_hold ? (w_req & (r_owner ? 2'b10 : 2'b01)) : w_req;

   // Tie goes to whichever master was not granted last.
   always_comb begin
      w_gnt = 1'b0;
      if (w_elig == 2'b11) begin
         w_gnt = ~r_last_grant;
      end else if (w_elig[1]) begin
         w_gnt = 1'b1;
      end
   end

   assign w_sel_we    = w_gnt ? m1.we    : m0.we;
   assign w_sel_lock  = w_gnt ? m1.lock  : m0.lock;
   assign w_sel_addr  = w_gnt ? m1.addr  : m0.addr;
   assign w_sel_wdata = w_gnt ? m1.wdata : m0.wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_owner       <= 1'b0;
         r_we          <= 1'b0;
         r_last_grant  <= 1'b1;
         r_lock_active <= 1'b0;
         r_cnt         <= '0;
         r_ack0        <= 1'b0;
         r_ack1        <= 1'b0;
         r_rdata0      <= '0;
         r_rdata1      <= '0;
         p_A           <= '0;
         p_WD          <= '0;
         p_WE          <= 1'b0;
         lock_timeout  <= 1'b0;
      end else begin
         lock_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!r_lock_active || w_owner_req) begin
                  r_cnt <= '0;
               end else if (w_force_release) begin
                  r_lock_active <= 1'b0;
                  lock_timeout  <= 1'b1;
                  r_cnt         <= '0;
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
               // A grant in the same cycle as a forced release overrides the
               // lock state with the new grantee's lock request.
               if (w_elig != 2'b00) begin
                  r_owner       <= w_gnt;
                  r_last_grant  <= w_gnt;
                  r_lock_active <= w_sel_lock;
                  r_cnt         <= '0;
                  r_we          <= w_sel_we;
                  p_A           <= w_sel_addr;
                  p_WD          <= w_sel_wdata;
                  p_WE          <= w_sel_we;
                  r_state       <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               p_WE <= 1'b0;
               if (!r_we) begin
                  if (r_owner) begin
                     r_rdata1 <= p_RD;
                  end else begin
                     r_rdata0 <= p_RD;
                  end
               end
               if (r_owner) begin
                  r_ack1 <= 1'b1;
               end else begin
                  r_ack0 <= 1'b1;
               end
               r_state <= S_RESP;
            end
            S_RESP: begin
               r_ack0  <= 1'b0;
               r_ack1  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               p_WE    <= 1'b0;
               r_ack0  <= 1'b0;
               r_ack1  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign m0.ack   = r_ack0;
   assign m1.ack   = r_ack1;
   assign m0.rdata = r_rdata0;
   assign m1.rdata = r_rdata1;

endmodule
`default_nettype wire
